// File: rtl/bnn_wx_mem.sv
// bnn_wx_mem: banked 1-bit weight/activation memory serving the binarized-NN
// compute engine. A serial loader port preloads weights and activations,
// mem_ready gates the engine, and err flags illegal accesses until reset.
// The activation clear walk assumes X_DEPTH and the bank count are powers of two.
// Optional build macro: BNN_WX_MEM_RDREG_EN registers w_data/x_data (1-cycle
// read latency, outputs held at 0 outside SERVE). Undefined: combinational reads.
module bnn_wx_mem #(
    parameter int W_ADDR_LEN = 20,
    parameter int W_SEL_LEN  = 2,
    parameter int X_ADDR_LEN = 10,
    parameter int X_SEL_LEN  = 2,
    parameter int W_DEPTH    = 16,
    parameter int X_DEPTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W_ADDR_LEN-1:0] w_addr,
    input  logic [W_SEL_LEN-1:0]  w_sel,
    input  logic                  w_wq,
    output logic                  w_data,
    input  logic [X_ADDR_LEN-1:0] x_addr,
    input  logic [X_SEL_LEN-1:0]  x_sel,
    input  logic                  x_wq,
    input  logic                  wx_write,
    output logic                  x_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic                  ld_target,
    input  logic [1:0]            ld_sel,
    input  logic [W_ADDR_LEN-1:0] ld_addr,
    input  logic                  ld_bit,
    input  logic                  start,
    output logic                  mem_ready,
    output logic                  err
);

    localparam int W_BANKS  = 1 << W_SEL_LEN;
    localparam int X_BANKS  = 1 << X_SEL_LEN;
    localparam int WIW      = $clog2(W_DEPTH);
    localparam int XIW      = $clog2(X_DEPTH);
    localparam int CLR_W    = $clog2(X_BANKS * X_DEPTH);
    localparam int CLR_LAST = X_BANKS * X_DEPTH - 1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CLR_W-1:0] clr_cnt;
    logic             clr_last;
    logic             clearing;

    logic w_mem [W_BANKS][W_DEPTH];
    logic x_mem [X_BANKS][X_DEPTH];

    logic w_in_range;
    logic x_in_range;
    logic ld_w_in_range;
    logic ld_x_in_range;
    logic ld_fire;
    logic w_rd;
    logic x_rd;
    logic err_set;

    // Address decode: anything at or beyond the implemented depth is out of range.
    assign w_in_range    = 32'(w_addr)  < 32'(W_DEPTH);
    assign x_in_range    = 32'(x_addr)  < 32'(X_DEPTH);
    assign ld_w_in_range = 32'(ld_addr) < 32'(W_DEPTH);
    assign ld_x_in_range = 32'(ld_addr) < 32'(X_DEPTH);

    assign clr_last = (clr_cnt == CLR_W'(CLR_LAST));
    assign ld_fire  = ld_valid && ld_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: clear once, then toggle LOAD/SERVE on the start level.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        state_next = state;
        case (state)
            ST_CLEAR: if (clr_last) state_next = ST_LOAD;
            ST_LOAD:  if (start)    state_next = ST_SERVE;
            ST_SERVE: if (!start)   state_next = ST_LOAD;
            default:                state_next = ST_CLEAR;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        ld_ready  = (state == ST_LOAD);
        mem_ready = (state == ST_SERVE);
        clearing  = (state == ST_CLEAR);
    end

    // Clear-walk counter: runs only in CLEAR, parked at 0 everywhere else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_cnt <= '0;
        end else if (clearing) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            clr_cnt <= clr_cnt + 1'b1;
        end else begin
            clr_cnt <= '0;
        end
    end

    // Weight array: written only by loader beats.
    // NOTE: the storage arrays carry no reset; activations are zeroed by the CLEAR walk instead.
    always_ff @(posedge clk) begin
        if (ld_fire && !ld_target && ld_w_in_range) begin
            w_mem[ld_sel][ld_addr[WIW-1:0]] <= ld_bit;
        end
    end

    // Activation array: clear walk, loader beats, or engine writes, by state.
    always_ff @(posedge clk) begin
        if (clearing) begin
            x_mem[clr_cnt[CLR_W-1 -: X_SEL_LEN]][clr_cnt[XIW-1:0]] <= 1'b0;
        end else if (ld_fire && ld_target && ld_x_in_range) begin
            x_mem[ld_sel][ld_addr[XIW-1:0]] <= ld_bit;
        end else if (mem_ready && x_wq && x_in_range) begin
            x_mem[x_sel][x_addr[XIW-1:0]] <= wx_write;
        end
    end

    // Sticky error: dropped out-of-range writes or any engine weight-write request.
    assign err_set = (ld_fire && !ld_target && !ld_w_in_range)
                   || (ld_fire && ld_target && !ld_x_in_range)
                   || (mem_ready && x_wq && !x_in_range)
                   || (mem_ready && w_wq);

    // Error flag: set-only until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

    // Raw array reads; out-of-range addresses read 0. A same-edge write is not yet visible.
    assign w_rd = w_in_range ? w_mem[w_sel][w_addr[WIW-1:0]] : 1'b0;
    assign x_rd = x_in_range ? x_mem[x_sel][x_addr[XIW-1:0]] : 1'b0;

`ifdef BNN_WX_MEM_RDREG_EN
    // Registered read data: captured only while serving, zero otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_data <= 1'b0;
            x_data <= 1'b0;
        end else if (mem_ready) begin
            w_data <= w_rd;
            x_data <= x_rd;
        end else begin
            w_data <= 1'b0;
            x_data <= 1'b0;
        end
    end
`else
    // Combinational read data, forced to 0 while the activation clear is running.
    always_comb begin
        w_data = clearing ? 1'b0 : w_rd;
        x_data = clearing ? 1'b0 : x_rd;
    end
`endif

endmodule
